// File: rtl/vload_read_arbiter.sv
// vload_read_arbiter: round-robin arbiter that lets several vector-load
// requesters share one memory read port. Each accepted burst gets a slot
// (slot index = ar_id), and returning beats go back to that slot's owner.
//
// Handshake rule on every valid/ready pair in this block: a transfer happens
// on a rising clk edge where valid and ready are both 1. Once the block
// raises ar_valid it keeps ar_addr/ar_len/ar_id stable until ar_ready.
// req_ready is a single-cycle grant pulse: the requester is accepted in the
// cycle where req_valid and req_ready are both 1.
module vload_read_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int NUM_SLOTS = 4,
  parameter int ADDR_W    = 32,
  localparam int ID_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int REQ_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0][7:0]        req_len,
  output logic                           ar_valid,
  input  logic                           ar_ready,
  output logic [ADDR_W-1:0]              ar_addr,
  output logic [7:0]                     ar_len,
  output logic [ID_W-1:0]                ar_id,
  input  logic                           r_valid,
  input  logic                           r_last,
  input  logic [ID_W-1:0]                r_id,
  output logic                           r_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic                           rsp_last,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  input  logic                           drain,
  output logic                           idle,
  output logic [1:0]                     dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_SLOTS-1:0]   busy_q, busy_d;
  logic [REQ_W-1:0]       owner_q [NUM_SLOTS];
  logic [REQ_W-1:0]       owner_d [NUM_SLOTS];
  logic [REQ_W-1:0]       last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]      ar_addr_q, ar_addr_d;
  logic [7:0]             ar_len_q, ar_len_d;
  logic [ID_W-1:0]        ar_id_q, ar_id_d;
  logic                   err_unexp_id_q;

  logic                   gnt_found;
  logic [REQ_W-1:0]       gnt_idx;
  logic                   free_found;
  logic [ID_W-1:0]        free_idx;
  logic                   grant;
  logic                   slot_hit;
  logic                   slot_free;
  logic                   unexp_beat;

  // Round-robin pick: first valid requester after the last granted one.
  always_comb begin
    int cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(last_grant_q) + 1 + i) % NUM_REQ;
      if (!gnt_found && req_valid[REQ_W'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = REQ_W'(cand);
      end
    end
  end

  // Lowest-index free slot, judged on registered busy bits so a slot freed
  // this cycle only becomes allocatable next cycle.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (!busy_q[ID_W'(s)]) begin
        free_found = 1'b1;
        free_idx   = ID_W'(s);
      end
    end
  end

  // Return routing: beats for a busy slot go to its owner; beats for an
  // idle slot are swallowed and flagged.
  always_comb begin
    slot_hit  = busy_q[r_id];
    rsp_valid = '0;
    r_ready   = 1'b0;
    if (rst_n) begin
      if (slot_hit) begin
        rsp_valid[owner_q[r_id]] = r_valid;
        r_ready                  = rsp_ready[owner_q[r_id]];
      end else begin
        r_ready = 1'b1;
      end
    end
    slot_free  = r_valid && r_ready && r_last && slot_hit;
    unexp_beat = r_valid && !slot_hit && rst_n;
  end

  // FSM next state, grant pulse, slot allocation and release.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    ar_addr_d    = ar_addr_q;
    ar_len_d     = ar_len_q;
    ar_id_d      = ar_id_q;
    req_ready    = '0;
    grant        = 1'b0;
    case (state_q)
      IDLE: begin
        if (drain) begin
          state_d = DRAIN;
        end else if (gnt_found && free_found && rst_n) begin
          grant              = 1'b1;
          req_ready[gnt_idx] = 1'b1;
          last_grant_d       = gnt_idx;
          ar_addr_d          = req_addr[gnt_idx];
          ar_len_d           = req_len[gnt_idx];
          ar_id_d            = free_idx;
          state_d            = ISSUE;
        end
      end
      ISSUE: begin
        if (ar_ready) state_d = drain ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (!drain && busy_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (slot_free) busy_d[r_id] = 1'b0;
    if (grant) begin
      busy_d[free_idx]  = 1'b1;
      owner_d[free_idx] = gnt_idx;
    end
  end

  // State and slot table registers; reset drops all outstanding bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      busy_q         <= '0;
      owner_q        <= '{default: '0};
      last_grant_q   <= REQ_W'(NUM_REQ - 1);
      ar_addr_q      <= '0;
      ar_len_q       <= '0;
      ar_id_q        <= '0;
      err_unexp_id_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      owner_q        <= owner_d;
      last_grant_q   <= last_grant_d;
      ar_addr_q      <= ar_addr_d;
      ar_len_q       <= ar_len_d;
      ar_id_q        <= ar_id_d;
      err_unexp_id_q <= err_unexp_id_q | unexp_beat;
    end
  end

  assign ar_valid  = (state_q == ISSUE);
  assign ar_addr   = ar_addr_q;
  assign ar_len    = ar_len_q;
  assign ar_id     = ar_id_q;
  assign rsp_last  = r_last;
  assign idle      = !rst_n || (state_q == IDLE && busy_q == '0 && req_valid == '0);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vload_read_arbiter.sv
// Bench for vload_read_arbiter: routing vector table, AR scoreboard and
// hand-written sequences for grant order, stalls, slot reuse, drain, reset.
module tb_vload_read_arbiter;

  localparam int W = 32 + 8 + 2;

  logic             clk;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_addr;
  logic [1:0][7:0]  req_len;
  logic             ar_valid;
  logic             ar_ready;
  logic [31:0]      ar_addr;
  logic [7:0]       ar_len;
  logic [1:0]       ar_id;
  logic             r_valid;
  logic             r_last;
  logic [1:0]       r_id;
  logic             r_ready;
  logic [1:0]       rsp_valid;
  logic             rsp_last;
  logic [1:0]       rsp_ready;
  logic             drain;
  logic             idle;
  logic [1:0]       dbg_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       rv;
    logic       rl;
    logic [1:0] rid;
    logic [1:0] rdy;
    logic [1:0] exp_rsp_valid;
    logic       exp_r_ready;
  } rvec_t;
  rvec_t vtab[8];

  vload_read_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .ar_valid  (ar_valid),
    .ar_ready  (ar_ready),
    .ar_addr   (ar_addr),
    .ar_len    (ar_len),
    .ar_id     (ar_id),
    .r_valid   (r_valid),
    .r_last    (r_last),
    .r_id      (r_id),
    .r_ready   (r_ready),
    .rsp_valid (rsp_valid),
    .rsp_last  (rsp_last),
    .rsp_ready (rsp_ready),
    .drain     (drain),
    .idle      (idle),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // AR scoreboard: each accepted AR must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && ar_valid && ar_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL ar_unexpected: got addr 0x%0h id %0d with nothing expected", ar_addr, ar_id);
      end else begin
        mon_exp = exp_q.pop_front();
        check("ar_fields", {ar_addr, ar_len, ar_id}, mon_exp);
      end
    end
  end

  task automatic wait_ar();
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    check("ar_drained", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_ar_valid", ar_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_r_ready", r_ready, 0);
    check("rst_ar_fields", {ar_addr, ar_len, ar_id}, 0);
    check("rst_idle", idle, 1);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_state", dbg_state, 2'd0);
    check("post_rst_err", dut.err_unexp_id_q, 0);
    tick();
  endtask

  // One requester asks; expects a grant within a bounded time and an AR with id
  task automatic issue(input int r, input logic [31:0] a, input logic [7:0] l, input logic [1:0] id);
    logic       got;
    logic [1:0] oh;
    got   = 1'b0;
    oh    = '0;
    oh[r] = 1'b1;
    req_valid[r] = 1'b1;
    req_addr[r]  = a;
    req_len[r]   = l;
    for (int k = 0; k < 20 && !got; k++) begin
      #1;
      if (req_ready[r]) begin
        got = 1'b1;
        check("grant_onehot", req_ready, oh);
        exp_q.push_back({a, l, id});
      end
      tick();
    end
    req_valid[r] = 1'b0;
    check("grant_seen", got, 1);
    wait_ar();
  endtask

  initial begin
    logic [1:0] ord[4];
    int         ng;
    int         beats;

    vtab[0] = '{1'b1, 1'b0, 2'd1, 2'b10, 2'b10, 1'b1};
    vtab[1] = '{1'b1, 1'b0, 2'd1, 2'b00, 2'b10, 1'b0};
    vtab[2] = '{1'b1, 1'b0, 2'd1, 2'b01, 2'b10, 1'b0};
    vtab[3] = '{1'b1, 1'b0, 2'd0, 2'b01, 2'b01, 1'b1};
    vtab[4] = '{1'b1, 1'b0, 2'd2, 2'b10, 2'b01, 1'b0};
    vtab[5] = '{1'b1, 1'b0, 2'd3, 2'b10, 2'b10, 1'b1};
    vtab[6] = '{1'b0, 1'b1, 2'd3, 2'b11, 2'b00, 1'b1};
    vtab[7] = '{1'b1, 1'b0, 2'd2, 2'b11, 2'b01, 1'b1};
    ord[0] = 2'b01; ord[1] = 2'b10; ord[2] = 2'b01; ord[3] = 2'b10;

    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_len = '0;
    ar_ready = 1'b0; r_valid = 1'b0; r_last = 1'b0; r_id = '0;
    rsp_ready = '0; drain = 1'b0;
    tick();
    do_reset();

    // Both requesters hold valid: grants alternate, ids 0..3, fifth withheld
    ar_ready = 1'b1;
    req_valid = 2'b11;
    req_addr[0] = 32'hA000; req_len[0] = 8'd1;
    req_addr[1] = 32'hB000; req_len[1] = 8'd2;
    exp_q.push_back({32'hA000, 8'd1, 2'd0});
    exp_q.push_back({32'hB000, 8'd2, 2'd1});
    exp_q.push_back({32'hA000, 8'd1, 2'd2});
    exp_q.push_back({32'hB000, 8'd2, 2'd3});
    ng = 0;
    for (int k = 0; k < 14; k++) begin
      #1;
      if (req_ready != 2'b00) begin
        if (ng < 4) check("rr_order", req_ready, ord[ng]);
        else check("grant_when_full", req_ready, 2'b00);
        ng++;
      end
      tick();
    end
    check("grant_count", ng, 4);
    check("full_no_ready", req_ready, 2'b00);
    check("full_state_idle", dbg_state, 2'd0);
    req_valid = 2'b00;
    wait_ar();

    // Return routing vectors with owners {0,1,0,1}
    for (int i = 0; i < 8; i++) begin
      r_valid = vtab[i].rv; r_last = vtab[i].rl; r_id = vtab[i].rid; rsp_ready = vtab[i].rdy;
      #1;
      check("vec_rsp_valid", rsp_valid, vtab[i].exp_rsp_valid);
      check("vec_r_ready", r_ready, vtab[i].exp_r_ready);
      check("vec_rsp_last", rsp_last, vtab[i].rl);
      tick();
    end
    r_valid = 1'b0; r_last = 1'b0; rsp_ready = '0;
    check("vec_no_err", dut.err_unexp_id_q, 0);

    // All busy; slot 2 frees in the same cycle a request arrives
    req_valid[0] = 1'b1; req_addr[0] = 32'hC000; req_len[0] = 8'd5;
    r_valid = 1'b1; r_id = 2'd2; r_last = 1'b1; rsp_ready = 2'b01;
    #1;
    check("free_cycle_no_grant", req_ready, 2'b00);
    check("free_cycle_rsp_valid", rsp_valid, 2'b01);
    tick();
    r_valid = 1'b0; r_last = 1'b0; rsp_ready = '0;
    #1;
    check("grant_after_free", req_ready, 2'b01);
    exp_q.push_back({32'hC000, 8'd5, 2'd2});
    tick();
    req_valid = 2'b00;
    wait_ar();

    // Four beats on slot 1 with rsp_ready[1] toggling
    r_valid = 1'b1; r_id = 2'd1; beats = 0;
    for (int k = 0; k < 16 && beats < 4; k++) begin
      rsp_ready = (k % 2 == 0) ? 2'b10 : 2'b00;
      r_last = (beats == 3);
      #1;
      check("burst_rsp_valid", rsp_valid, 2'b10);
      check("burst_r_ready", r_ready, rsp_ready[1]);
      check("burst_rsp_last", rsp_last, r_last);
      if (rsp_ready[1]) beats++;
      tick();
    end
    r_valid = 1'b0; r_last = 1'b0; rsp_ready = '0;
    check("burst_beats", beats, 4);
    issue(1, 32'hD000, 8'd7, 2'd1);

    // Free slot 0, then free slot 3 while slot 0 is allocated
    r_valid = 1'b1; r_id = 2'd0; r_last = 1'b1; rsp_ready = 2'b01;
    tick();
    req_valid[0] = 1'b1; req_addr[0] = 32'hE000; req_len[0] = 8'd0;
    r_id = 2'd3; rsp_ready = 2'b10;
    #1;
    check("simul_grant", req_ready, 2'b01);
    check("simul_rsp_valid", rsp_valid, 2'b10);
    exp_q.push_back({32'hE000, 8'd0, 2'd0});
    tick();
    req_valid = 2'b00; r_valid = 1'b0; r_last = 1'b0; rsp_ready = '0;
    wait_ar();
    issue(1, 32'hF000, 8'd2, 2'd3);

    // AR stall: fields held while ar_ready low
    do_reset();
    ar_ready = 1'b0;
    req_valid[0] = 1'b1; req_addr[0] = 32'h1000; req_len[0] = 8'd3;
    #1;
    check("stall_grant", req_ready, 2'b01);
    exp_q.push_back({32'h1000, 8'd3, 2'd0});
    tick();
    req_valid = 2'b00;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_ar_valid", ar_valid, 1);
      check("stall_fields", {ar_addr, ar_len, ar_id}, {32'h1000, 8'd3, 2'd0});
      check("stall_req_ready", req_ready, 2'b00);
      tick();
    end
    ar_ready = 1'b1;
    wait_ar();
    #1;
    check("stall_ar_done", ar_valid, 0);
    tick();

    // Drain with two slots busy and a held request
    do_reset();
    ar_ready = 1'b1;
    issue(0, 32'h2000, 8'd1, 2'd0);
    issue(1, 32'h3000, 8'd1, 2'd1);
    drain = 1'b1;
    req_valid[0] = 1'b1; req_addr[0] = 32'h4000; req_len[0] = 8'd2;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("drain_no_ready", req_ready, 2'b00);
      if (k > 0) check("drain_state", dbg_state, 2'd2);
      tick();
    end
    r_valid = 1'b1; r_last = 1'b1; r_id = 2'd0; rsp_ready = 2'b01;
    #1;
    check("drain_beat0_rsp", rsp_valid, 2'b01);
    tick();
    r_id = 2'd1; rsp_ready = 2'b10;
    #1;
    check("drain_beat1_rsp", rsp_valid, 2'b10);
    tick();
    r_valid = 1'b0; r_last = 1'b0; rsp_ready = '0;
    #1;
    check("drain_hold_ready", req_ready, 2'b00);
    check("drain_not_idle", idle, 0);
    tick();
    drain = 1'b0;
    #1;
    check("drain_exit_ready", req_ready, 2'b00);
    tick();
    #1;
    check("drain_resume_grant", req_ready, 2'b01);
    exp_q.push_back({32'h4000, 8'd2, 2'd0});
    tick();
    req_valid = 2'b00;
    wait_ar();

    // Reset during ISSUE with three slots busy
    do_reset();
    ar_ready = 1'b1;
    issue(0, 32'h6000, 8'd0, 2'd0);
    issue(1, 32'h7000, 8'd0, 2'd1);
    issue(0, 32'h8000, 8'd0, 2'd2);
    ar_ready = 1'b0;
    req_valid[1] = 1'b1; req_addr[1] = 32'h5000; req_len[1] = 8'd4;
    #1;
    check("pre_rst_grant", req_ready, 2'b10);
    tick();
    req_valid = 2'b00;
    #1;
    check("pre_rst_ar_valid", ar_valid, 1);
    check("pre_rst_ar_id", ar_id, 2'd3);
    check("pre_rst_err", dut.err_unexp_id_q, 0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ar_valid", ar_valid, 0);
    check("mid_rst_idle", idle, 1);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("after_rst_idle", idle, 1);
    tick();
    r_valid = 1'b1; r_id = 2'd1; r_last = 1'b1; rsp_ready = 2'b11;
    #1;
    check("stale_rsp_valid", rsp_valid, 2'b00);
    check("stale_r_ready", r_ready, 1);
    tick();
    r_valid = 1'b0; r_last = 1'b0; rsp_ready = '0;
    #1;
    check("stale_err", dut.err_unexp_id_q, 1);
    check("stale_idle", idle, 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
